// File: rtl/cvita_sched_pkg.sv
// rtl/cvita_sched_pkg.sv - shared types and helpers for the CVITA frame scheduler
package cvita_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PASS = 2'd1,
        S_PAD  = 2'd2,
        S_DROP = 2'd3
    } state_t;

    localparam int CVITA_LEN_MSB = 47;
    localparam int CVITA_LEN_LSB = 32;

    // Packet length in bytes -> number of 64-bit words, rounded up
    function automatic logic [16:0] cvita_words(input logic [15:0] len);
        logic [16:0] sum;
        sum = {1'b0, len} + 17'd7;
        return {3'b000, sum[16:3]};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at a pointer
module rr_arbiter #(
    parameter int NUM_INPUTS = 4,
    parameter int IDXW       = $clog2(NUM_INPUTS)
) (
    input  logic [NUM_INPUTS-1:0] req,
    input  logic [IDXW-1:0]       ptr,
    output logic [NUM_INPUTS-1:0] gnt,
    output logic [IDXW-1:0]       idx
);

    logic            found;
    logic [IDXW-1:0] cand;

    // Scan from ptr upward with wrap; first requester wins
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            cand = IDXW'((int'(ptr) + i) % NUM_INPUTS);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/cvita_frame_scheduler.sv
// rtl/cvita_frame_scheduler.sv - packs whole CVITA packets from N sources into fixed-size padded frames
module cvita_frame_scheduler
    import cvita_sched_pkg::*;
#(
    parameter int          NUM_INPUTS    = 4,
    parameter int          FLUSH_TIMEOUT = 64,
    parameter logic [63:0] PAD_WORD      = 64'h0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic [15:0]              frame_size,
    input  logic [64*NUM_INPUTS-1:0] i_tdata,
    input  logic [NUM_INPUTS-1:0]    i_tlast,
    input  logic [NUM_INPUTS-1:0]    i_tvalid,
    output logic [NUM_INPUTS-1:0]    i_tready,
    output logic [63:0]              o_tdata,
    output logic                     o_tlast,
    output logic                     o_tvalid,
    input  logic                     o_tready,
    output logic                     error
);

    localparam int IDXW = $clog2(NUM_INPUTS);

    state_t          state_q, state_d;
    logic [IDXW-1:0] g_q, g_d, rr_q, rr_d, arb_idx;
    logic [16:0]     words_q, words_d, cnt_q, cnt_d, hdr_words;
    logic [15:0]     rem_q, rem_d, idle_q, idle_d, rem_eff;
    logic            open_q, open_d, discard_q, discard_d, pad_pass_q, pad_pass_d;
    logic            err_q, err_d, o_tvalid_q, o_tvalid_d, o_tlast_q, o_tlast_d;
    logic [63:0]     o_tdata_q, o_tdata_d;
    logic [NUM_INPUTS-1:0] arb_gnt;
    logic [63:0]     in_data [NUM_INPUTS];
    logic            out_free, xfer_in, arb_any, timeout;

    for (genvar n = 0; n < NUM_INPUTS; n++) begin : g_unpack
        assign in_data[n] = i_tdata[64*n +: 64];
    end

    rr_arbiter #(.NUM_INPUTS(NUM_INPUTS), .IDXW(IDXW)) u_arb (
        .req (i_tvalid),
        .ptr (rr_q),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    assign arb_any   = |arb_gnt;
    assign out_free  = !o_tvalid_q || o_tready;
    assign xfer_in   = (state_q == S_PASS || state_q == S_DROP) && out_free && i_tvalid[g_q];
    assign rem_eff   = open_q ? rem_q : frame_size;
    assign hdr_words = cvita_words(in_data[arb_idx][CVITA_LEN_MSB:CVITA_LEN_LSB]);
    assign timeout   = open_q && (idle_q == 16'(FLUSH_TIMEOUT - 1));

    function automatic logic [IDXW-1:0] rr_next(input logic [IDXW-1:0] g);
        return (g == IDXW'(NUM_INPUTS - 1)) ? '0 : g + 1'b1;
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (reset || clear) state_q <= S_IDLE;
        else                state_q <= state_d;
    end

    // Next-state decision
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (arb_any) begin
                    if (hdr_words > {1'b0, frame_size})    state_d = S_DROP;
                    else if (hdr_words <= {1'b0, rem_eff}) state_d = S_PASS;
                    else                                   state_d = S_PAD;
                end else if (timeout) begin
                    state_d = S_PAD;
                end
            end
            S_PASS, S_DROP: if (xfer_in && i_tlast[g_q]) state_d = S_IDLE;
            S_PAD:          if (out_free && rem_q == 16'd1) state_d = pad_pass_q ? S_PASS : S_IDLE;
            default:        state_d = S_IDLE;
        endcase
    end

    // Only the granted source is ready, and only when the output register can take a word
    always_comb begin
        i_tready = '0;
        if ((state_q == S_PASS || state_q == S_DROP) && out_free) i_tready[g_q] = 1'b1;
    end

    // Frame bookkeeping and output register loading
    always_comb begin
        g_d        = g_q;
        rr_d       = rr_q;
        words_d    = words_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        idle_d     = idle_q;
        open_d     = open_q;
        discard_d  = discard_q;
        pad_pass_d = pad_pass_q;
        err_d      = err_q;
        o_tvalid_d = o_tvalid_q && !o_tready;
        o_tdata_d  = o_tdata_q;
        o_tlast_d  = o_tlast_q;
        case (state_q)
            S_IDLE: begin
                rem_d = rem_eff;
                if (arb_any) begin
                    g_d        = arb_idx;
                    words_d    = hdr_words;
                    cnt_d      = '0;
                    discard_d  = 1'b0;
                    idle_d     = '0;
                    pad_pass_d = 1'b1;
                end else if (timeout) begin
                    idle_d     = '0;
                    pad_pass_d = 1'b0;
                end else if (open_q) begin
                    idle_d = idle_q + 16'd1;
                end else begin
                    idle_d = '0;
                end
            end
            S_PASS: if (xfer_in) begin
                cnt_d = cnt_q + 17'd1;
                // A packet overrunning the frame is swallowed rather than split
                if (!discard_q) begin
                    o_tvalid_d = 1'b1;
                    o_tdata_d  = in_data[g_q];
                    o_tlast_d  = (rem_q == 16'd1);
                    open_d     = 1'b1;
                    if (rem_q == 16'd1) begin
                        rem_d  = frame_size;
                        open_d = 1'b0;
                        if (!i_tlast[g_q]) begin
                            discard_d = 1'b1;
                            err_d     = 1'b1;
                        end
                    end else begin
                        rem_d = rem_q - 16'd1;
                    end
                end
                if (i_tlast[g_q]) begin
                    rr_d = rr_next(g_q);
                    if (cnt_q + 17'd1 != words_q) err_d = 1'b1;
                end
            end
            S_PAD: if (out_free) begin
                o_tvalid_d = 1'b1;
                o_tdata_d  = PAD_WORD;
                o_tlast_d  = (rem_q == 16'd1);
                if (rem_q == 16'd1) begin
                    rem_d  = frame_size;
                    open_d = 1'b0;
                end else begin
                    rem_d = rem_q - 16'd1;
                end
            end
            S_DROP: if (xfer_in) begin
                err_d = 1'b1;
                if (i_tlast[g_q]) rr_d = rr_next(g_q);
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            g_q        <= '0;
            rr_q       <= '0;
            words_q    <= '0;
            cnt_q      <= '0;
            rem_q      <= frame_size;
            idle_q     <= '0;
            open_q     <= 1'b0;
            discard_q  <= 1'b0;
            pad_pass_q <= 1'b0;
            err_q      <= 1'b0;
            o_tvalid_q <= 1'b0;
            o_tdata_q  <= '0;
            o_tlast_q  <= 1'b0;
        end else begin
            g_q        <= g_d;
            rr_q       <= rr_d;
            words_q    <= words_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            idle_q     <= idle_d;
            open_q     <= open_d;
            discard_q  <= discard_d;
            pad_pass_q <= pad_pass_d;
            err_q      <= err_d;
            o_tvalid_q <= o_tvalid_d;
            o_tdata_q  <= o_tdata_d;
            o_tlast_q  <= o_tlast_d;
        end
    end

    assign o_tdata  = o_tdata_q;
    assign o_tlast  = o_tlast_q;
    assign o_tvalid = o_tvalid_q;
    assign error    = err_q;

endmodule

// File: tb/tb_cvita_frame_scheduler.sv
// tb/tb_cvita_frame_scheduler.sv - scoreboard bench for cvita_frame_scheduler
module tb_cvita_frame_scheduler;

    localparam int N  = 4;
    localparam int FT = 64;

    logic            clk = 1'b0;
    logic            reset, clear, o_tready, o_tlast, o_tvalid, error;
    logic [15:0]     frame_size;
    logic [64*N-1:0] i_tdata;
    logic [N-1:0]    i_tlast, i_tvalid, i_tready, fire_v;
    logic [63:0]     o_tdata;

    logic [64:0] src [N][$];
    logic [64:0] exp_q [$];
    int          xfer_cnt [N];
    int          n_pass = 0;
    int          n_chk  = 0;
    bit          rand_rdy = 1'b0;
    bit          rdy_force = 1'b1;

    always #5 clk = ~clk;

    cvita_frame_scheduler #(.NUM_INPUTS(N), .FLUSH_TIMEOUT(FT), .PAD_WORD(64'h0)) dut (
        .clk(clk), .reset(reset), .clear(clear), .frame_size(frame_size),
        .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
        .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
        .error(error)
    );

    function automatic logic [63:0] pkt_word(int p, int k, int len, int w);
        if (w == 0) return {16'hC0DE, 16'(len), 8'(p), 8'(k), 16'h0000};
        return {16'hDA7A, 8'(p), 8'(k), 32'(w)};
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    task automatic send(int p, int k, int len, int nw);
        for (int w = 0; w < nw; w++) src[p].push_back({w == nw - 1, pkt_word(p, k, len, w)});
    endtask

    task automatic expect_pkt(int p, int k, int len, int nw, bit last_end);
        for (int w = 0; w < nw; w++) exp_q.push_back({last_end && (w == nw - 1), pkt_word(p, k, len, w)});
    endtask

    task automatic expect_pad(int nw);
        for (int w = 0; w < nw; w++) exp_q.push_back({w == nw - 1, 64'h0});
    endtask

    task automatic wait_drain(string name, int budget);
        int c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            @(negedge clk);
            c++;
        end
        check({name, " drain (words left)"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        for (int n = 0; n < N; n++) begin
            src[n].delete();
            xfer_cnt[n] = 0;
        end
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; frame_size = 16'd10; o_tready = 1'b1;
        i_tdata = '0; i_tlast = '0; i_tvalid = '0; fire_v = '0;
        for (int n = 0; n < N; n++) xfer_cnt[n] = 0;

        fork
            // Source driver: pops a word after each accepted handshake
            forever begin
                @(negedge clk);
                fire_v = i_tvalid & i_tready;
                @(posedge clk);
                #1;
                for (int n = 0; n < N; n++) begin
                    if (fire_v[n] && src[n].size() > 0) begin
                        void'(src[n].pop_front());
                        xfer_cnt[n]++;
                    end
                    if (src[n].size() > 0) begin
                        i_tvalid[n]        = 1'b1;
                        i_tlast[n]         = src[n][0][64];
                        i_tdata[64*n +: 64] = src[n][0][63:0];
                    end else begin
                        i_tvalid[n]        = 1'b0;
                        i_tlast[n]         = 1'b0;
                        i_tdata[64*n +: 64] = '0;
                    end
                end
            end
            // Sink ready generator
            forever begin
                @(posedge clk);
                #1;
                o_tready = rand_rdy ? ($urandom_range(0, 2) != 0) : rdy_force;
            end
            // Output monitor
            forever begin
                @(negedge clk);
                if (o_tvalid && o_tready) begin
                    n_chk++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL out_word: got unexpected %b/%h expected none", o_tlast, o_tdata);
                    end else if ({o_tlast, o_tdata} === exp_q[0]) begin
                        n_pass++;
                        void'(exp_q.pop_front());
                    end else begin
                        $display("FAIL out_word: got %b/%h expected %b/%h",
                                 o_tlast, o_tdata, exp_q[0][64], exp_q[0][63:0]);
                        void'(exp_q.pop_front());
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst o_tvalid", 64'(o_tvalid), 64'd0);
        check("rst o_tlast", 64'(o_tlast), 64'd0);
        check("rst o_tdata", o_tdata, 64'd0);
        check("rst i_tready", 64'(i_tready), 64'd0);
        check("rst error", 64'(error), 64'd0);

        // 1: single 8-word packet, idle flush pads 2 words
        send(0, 1, 64, 8);
        expect_pkt(0, 1, 64, 8, 1'b0);
        expect_pad(2);
        wait_drain("t1", 300);
        check("t1 error", 64'(error), 64'd0);

        // 2: two 5-word packets fill the frame exactly
        do_clear();
        send(0, 2, 40, 5);
        send(1, 2, 40, 5);
        expect_pkt(0, 2, 40, 5, 1'b0);
        expect_pkt(1, 2, 40, 5, 1'b1);
        wait_drain("t2", 100);
        repeat (100) @(negedge clk);
        check("t2 error", 64'(error), 64'd0);

        // 3: second packet does not fit, pad then open next frame
        do_clear();
        send(0, 3, 64, 8);
        send(1, 3, 32, 4);
        expect_pkt(0, 3, 64, 8, 1'b0);
        expect_pad(2);
        expect_pkt(1, 3, 32, 4, 1'b0);
        expect_pad(6);
        wait_drain("t3", 400);
        check("t3 error", 64'(error), 64'd0);

        // 4: oversize packet dropped, error sticky
        do_clear();
        send(2, 4, 88, 11);
        for (int c = 0; c < 100 && xfer_cnt[2] < 11; c++) @(negedge clk);
        check("t4 drop xfers", 64'(xfer_cnt[2]), 64'd11);
        check("t4 error set", 64'(error), 64'd1);
        repeat (20) @(negedge clk);
        check("t4 error held", 64'(error), 64'd1);
        send(2, 5, 16, 2);
        expect_pkt(2, 5, 16, 2, 1'b0);
        expect_pad(8);
        wait_drain("t4", 300);
        check("t4 error still", 64'(error), 64'd1);
        do_clear();
        check("t4 error cleared", 64'(error), 64'd0);

        // 5: four sources, 1-word packets, frame of 4, random back-pressure
        do_clear();
        frame_size = 16'd4;
        rand_rdy = 1'b1;
        for (int k = 0; k < 3; k++)
            for (int p = 0; p < N; p++) send(p, 10 + k, 8, 1);
        for (int k = 0; k < 3; k++)
            for (int p = 0; p < N; p++) expect_pkt(p, 10 + k, 8, 1, p == N - 1);
        wait_drain("t5", 500);
        rand_rdy = 1'b0;
        check("t5 error", 64'(error), 64'd0);

        // 6: length mismatch then clear mid-packet
        do_clear();
        frame_size = 16'd10;
        send(0, 6, 16, 3);
        expect_pkt(0, 6, 16, 3, 1'b0);
        wait_drain("t6", 50);
        check("t6 error", 64'(error), 64'd1);
        rdy_force = 1'b0;
        send(1, 7, 40, 5);
        for (int c = 0; c < 20 && !o_tvalid; c++) @(negedge clk);
        check("t6 stalled valid", 64'(o_tvalid), 64'd1);
        clear = 1'b1;
        for (int n = 0; n < N; n++) src[n].delete();
        @(negedge clk);
        clear = 1'b0;
        check("t6 clr o_tvalid", 64'(o_tvalid), 64'd0);
        check("t6 clr o_tlast", 64'(o_tlast), 64'd0);
        check("t6 clr o_tdata", o_tdata, 64'd0);
        check("t6 clr i_tready", 64'(i_tready), 64'd0);
        check("t6 clr error", 64'(error), 64'd0);
        rdy_force = 1'b1;
        repeat (100) @(negedge clk);
        check("final exp empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cvita_frame_scheduler.md
Name: cvita_frame_scheduler

Overview:
Round-robin scheduler that shares one fixed-quantum framed CVITA link between NUM_INPUTS packet sources. It packs whole packets into frames of frame_size 64-bit words and never splits a packet across frames. When the next packet does not fit, or the link goes idle, it closes the open frame with pad words. It sits upstream of cvita_dechunker, which strips the padding at the far end of the link.

Parameters:
NUM_INPUTS, 4, number of requesting CVITA streams (2..8)
FLUSH_TIMEOUT, 64, idle cycles with a partially filled frame before the frame is padded out
PAD_WORD, 64'h0, tdata value emitted for pad words

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
clear  in  1  synchronous soft reset; same effect as reset, including on error
frame_size  in  16  frame length in 64-bit words; sampled only while no frame is open; must be >= 1
i_tdata  in  64*NUM_INPUTS  flattened input data; input n occupies bits [64n+63:64n]
i_tlast  in  NUM_INPUTS  end-of-packet flag per input
i_tvalid  in  NUM_INPUTS  valid flag per input
i_tready  out  NUM_INPUTS  ready flag per input; at most one bit set at a time
o_tdata  out  64  framed output data
o_tlast  out  1  last word of frame
o_tvalid  out  1  output valid
o_tready  in  1  output ready
error  out  1  sticky error flag; cleared only by reset/clear

Behaviour:
- Reset/clear: o_tvalid=0, o_tlast=0, o_tdata=0, i_tready=0, error=0, state=IDLE, rr_ptr=0, remaining=frame_size, open=0, idle_cnt=0.
- Packet word count: words = ceil(hdr[47:32]/8), from the header word (first word of the packet). Computed as 17-bit (len+7)>>3.
- Output is registered; the first output word appears 2 cycles after header valid (1 cycle arbitration + 1 register). AXI rule: o_tdata/o_tlast are held while o_tvalid & !o_tready. i_tready(g) = state==PASS/DROP & output register free.
- State IDLE:
  - Select the first n with i_tvalid[n], scanning from rr_ptr upward with wrap. Latch grant g and words_g.
  - words_g > frame_size -> DROP.
  - words_g <= remaining -> PASS.
  - Otherwise -> PAD, keeping grant g.
  - No request and open: increment idle_cnt; at FLUSH_TIMEOUT -> PAD. idle_cnt resets on any grant.
- State PASS:
  - Forward input g word by word; decrement remaining on each output transfer; set open=1.
  - o_tlast=1 on the word where remaining reaches 0.
  - On i_tlast: rr_ptr=g+1 (mod NUM_INPUTS). If remaining==0, close the frame (remaining=frame_size, open=0). Return to IDLE.
  - If the i_tlast position differs from words_g: set error.
  - Frame fills before i_tlast: forward nothing further; consume and discard words to i_tlast; set error.
- State PAD:
  - Emit PAD_WORD until remaining==0; o_tlast on the final pad word; then close the frame.
  - Next state: PASS for the held grant, or IDLE for a timeout flush.
- State DROP: consume packet g to i_tlast with no output; set error; rr_ptr=g+1; -> IDLE.
- A frame is never closed with zero words; an empty link emits nothing.
- Simultaneous requests: only the rr_ptr order matters; grant is held until i_tlast.
- clear mid-packet: abandon immediately, open frame is not completed. Upstream must also flush.

Decomposition:
- Package cvita_sched_pkg: state enum (IDLE, PASS, PAD, DROP), CVITA_LEN_MSB=47 / CVITA_LEN_LSB=32, word-count function.
- Sub-module rr_arbiter (NUM_INPUTS): request vector + pointer in, one-hot grant + index out, combinational.

Test Plan:
1. frame_size=10; in0 sends 64B (8 words) then goes idle -> 8 data words, then 2 PAD_WORD after FLUSH_TIMEOUT idle cycles; o_tlast on word 10 only; error=0.
2. frame_size=10; in0 and in1 each present 40B simultaneously -> in0's 5 words then in1's 5 words; o_tlast on in1 word 5; no padding.
3. frame_size=10; in0 64B, in1 32B both pending -> 8 in0 words, 2 pad words (tlast), then in1's 4 words opening the next frame.
4. frame_size=10; in2 sends 88B (11 words) -> 11 input transfers, zero output, error=1 held until clear; next legal packet passes.
5. All 4 inputs stream 8B packets continuously, frame_size=4 -> grant order 0,1,2,3,0,1,... with o_tlast every 4th word; random o_tready stalls lose or duplicate no words.
6. Header declares 16B but i_tlast is on word 3 -> 3 words forwarded, error=1. Then assert clear mid-packet -> outputs return to reset values next cycle.
